// File: rtl/wbu_pipeline_if.sv
// Upstream instruction bus into the write-back stage; master = load/store stage, slave = wbu_pipeline.
interface wbu_pipeline_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        in_reg_wen;
  logic        in_is_csr;
  logic        in_csr_wen;
  logic [11:0] in_csr_addr;
  logic [31:0] in_csr_wdata;
  logic        in_ebreak;
  logic        in_ecall;
  logic        in_mret;

  modport master (
    output in_valid, in_pc, in_inst, in_result, in_rd, in_reg_wen, in_is_csr,
           in_csr_wen, in_csr_addr, in_csr_wdata, in_ebreak, in_ecall, in_mret,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_result, in_rd, in_reg_wen, in_is_csr,
           in_csr_wen, in_csr_addr, in_csr_wdata, in_ebreak, in_ecall, in_mret,
    output in_ready
  );
endinterface

// File: rtl/wbu_pipeline.sv
// Write-back/commit stage: GPR and CSR writes commit on the accept edge, retire record one cycle later.
// Backpressure: in_ready drops for the redirect cycle after ecall/mret and stays low after ebreak; WBU_COUNTERS_EN adds mcycle/minstret.
module wbu_pipeline #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MVENDORID   = 32'h7973_7978,
  parameter logic [31:0] MARCHID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  wbu_pipeline_if.slave up,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        halt,
  output logic [31:0] halt_pc,
  output logic        retire_valid,
  output logic [31:0] retire_pc,
  output logic [31:0] retire_inst
);

  localparam int MIE  = 3;
  localparam int MPIE = 7;

  typedef enum logic [1:0] {S_RUN, S_REDIR, S_HALT} state_t;

  state_t      state, state_nxt;
  logic        run, acc, csr_wr;
  logic        do_ebreak, do_ecall, do_mret;
  logic [31:0] mstatus, mtvec, mepc, mcause;
  logic [31:0] mstatus_n, mtvec_n, mepc_n, mcause_n;
  logic [31:0] redir_target;
  logic        unused_is_csr;

  assign run         = (state == S_RUN);
  assign up.in_ready = run;
  assign acc         = up.in_valid && run;
  assign csr_wr      = acc && up.in_csr_wen;

  // ebreak wins over ecall, ecall over mret
  assign do_ebreak = acc && up.in_ebreak;
  assign do_ecall  = acc && up.in_ecall && !up.in_ebreak;
  assign do_mret   = acc && up.in_mret && !up.in_ecall && !up.in_ebreak;

  assign rf_wen        = acc && up.in_reg_wen;
  assign rf_waddr      = up.in_rd;
  assign rf_wdata      = up.in_result;
  assign unused_is_csr = up.in_is_csr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    halt           = 1'b0;
    case (state)
      S_RUN: begin
        if (do_ebreak)              state_nxt = S_HALT;
        else if (do_ecall || do_mret) state_nxt = S_REDIR;
      end
      S_REDIR: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        state_nxt      = S_RUN;
      end
      S_HALT:  halt = 1'b1;
      default: state_nxt = S_RUN;
    endcase
  end

  // Trap/return side effects are applied on top of any CSR write in the same instruction
  always_comb begin
    mstatus_n = mstatus;
    mtvec_n   = mtvec;
    mepc_n    = mepc;
    mcause_n  = mcause;
    if (csr_wr) begin
      case (up.in_csr_addr)
        12'h300: mstatus_n = up.in_csr_wdata;
        12'h305: mtvec_n   = up.in_csr_wdata;
        12'h341: mepc_n    = up.in_csr_wdata;
        12'h342: mcause_n  = up.in_csr_wdata;
        default: ;
      endcase
    end
    if (do_ecall) begin
      mepc_n           = up.in_pc;
      mcause_n         = 32'd11;
      mstatus_n[MPIE]  = mstatus_n[MIE];
      mstatus_n[MIE]   = 1'b0;
      mstatus_n[12:11] = 2'b11;
    end
    if (do_mret) begin
      mstatus_n[MIE]  = mstatus_n[MPIE];
      mstatus_n[MPIE] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus      <= 32'h0000_1800;
      mtvec        <= RESET_MTVEC;
      mepc         <= 32'h0;
      mcause       <= 32'h0;
      redir_target <= 32'h0;
      halt_pc      <= 32'h0;
      retire_valid <= 1'b0;
      retire_pc    <= 32'h0;
      retire_inst  <= 32'h0;
    end else begin
      mstatus      <= mstatus_n;
      mtvec        <= mtvec_n;
      mepc         <= mepc_n;
      mcause       <= mcause_n;
      retire_valid <= acc;
      if (do_ecall)     redir_target <= mtvec;
      else if (do_mret) redir_target <= mepc;
      if (do_ebreak) halt_pc <= up.in_pc;
      if (acc) begin
        retire_pc   <= up.in_pc;
        retire_inst <= up.in_inst;
      end
    end
  end

  assign redirect_pc = redir_target;

`ifdef WBU_COUNTERS_EN
  logic [63:0] mcycle, minstret, mcycle_n, minstret_n;

  // A CSR write to either half replaces that cycle's increment for the whole counter
  always_comb begin
    mcycle_n   = mcycle + 64'd1;
    minstret_n = minstret + {63'd0, acc};
    if (csr_wr) begin
      case (up.in_csr_addr)
        12'hB00: mcycle_n   = {mcycle[63:32], up.in_csr_wdata};
        12'hB80: mcycle_n   = {up.in_csr_wdata, mcycle[31:0]};
        12'hB02: minstret_n = {minstret[63:32], up.in_csr_wdata};
        12'hB82: minstret_n = {up.in_csr_wdata, minstret[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle   <= 64'h0;
      minstret <= 64'h0;
    end else begin
      mcycle   <= mcycle_n;
      minstret <= minstret_n;
    end
  end
`endif

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_raddr)
      12'h300: csr_rdata = mstatus;
      12'h305: csr_rdata = mtvec;
      12'h341: csr_rdata = mepc;
      12'h342: csr_rdata = mcause;
      12'hF11: csr_rdata = MVENDORID;
      12'hF12: csr_rdata = MARCHID;
`ifdef WBU_COUNTERS_EN
      12'hB00: csr_rdata = mcycle[31:0];
      12'hB80: csr_rdata = mcycle[63:32];
      12'hB02: csr_rdata = minstret[31:0];
      12'hB82: csr_rdata = minstret[63:32];
`endif
      default: csr_rdata = 32'h0;
    endcase
  end

endmodule

// File: doc/wbu_pipeline.md
# wbu_pipeline

Write-back stage of the five-stage pipeline, directly downstream of the load/store stage. It accepts one completed instruction per cycle over a valid/ready handshake and commits its results. Commit covers the GPR write port, the machine-mode CSR file, ecall/mret redirects with pipeline flush, and ebreak halt. It also emits a registered retire record for difftest.

## Interface
Parameters:
- `RESET_MTVEC`, default 32'h0000_0000: reset value of mtvec.
- `MVENDORID`, default 32'h7973_7978: constant returned for CSR 0xF11.
- `MARCHID`, default 32'h0000_0000: constant returned for CSR 0xF12.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: upstream instruction valid.
- `in_ready` output 1: stage can accept an instruction.
- `in_pc`, `in_inst`, `in_result` input 32 each: instruction PC, instruction word, write-back data.
- `in_rd` input 5: destination register.
- `in_reg_wen` input 1: GPR write enable. Upstream has already masked x0.
- `in_is_csr`, `in_csr_wen` input 1 each: CSR instruction flag, CSR write enable.
- `in_csr_addr` input 12: CSR address.
- `in_csr_wdata` input 32: CSR write data.
- `in_ebreak`, `in_ecall`, `in_mret` input 1 each: system instruction flags.
- `rf_wen` output 1, `rf_waddr` output 5, `rf_wdata` output 32: GPR write port.
- `csr_raddr` input 12, `csr_rdata` output 32: combinational CSR read port used by EXU.
- `redirect_valid` output 1, `redirect_pc` output 32: PC redirect to IFU.
- `flush` output 1: flush of all upstream stages.
- `halt` output 1: ebreak reached.
- `halt_pc` output 32: PC of the ebreak.
- `retire_valid` output 1, `retire_pc` output 32, `retire_inst` output 32: retire record for difftest.

## Operation
- State machine with three states: S_RUN, S_REDIR, S_HALT. Reset enters S_RUN.
- `in_ready` = (state==S_RUN). An instruction is accepted when `in_valid && in_ready` (call this `acc`).
- GPR write port is combinational:
  - `rf_wen` = acc && in_reg_wen.
  - `rf_waddr` = in_rd.
  - `rf_wdata` = in_result.
  - The regfile samples the port on the same edge.
- CSR write happens on acc && in_csr_wen.
  - Writable CSRs: mstatus 0x300 (reset 32'h0000_1800), mtvec 0x305 (reset RESET_MTVEC), mepc 0x341 (reset 0), mcause 0x342 (reset 0).
  - Writes to any other address are ignored.
- CSR reads return the current register value; the read port has no write bypass.
  - 0xF11 returns MVENDORID and 0xF12 returns MARCHID.
  - Unimplemented addresses read 0.
- ecall on acc:
  - mepc <= in_pc, mcause <= 11.
  - mstatus: MPIE <= MIE, MIE <= 0, MPP <= 2'b11.
  - Latch redirect target = current mtvec.
  - Transition S_RUN -> S_REDIR.
- mret on acc:
  - Latch redirect target = current mepc.
  - mstatus: MIE <= MPIE, MPIE <= 1.
  - Transition S_RUN -> S_REDIR.
- S_REDIR lasts exactly one cycle:
  - `redirect_valid` = `flush` = 1 and `redirect_pc` = latched target.
  - Then returns to S_RUN.
- ebreak on acc:
  - `halt_pc` <= in_pc.
  - Transition S_RUN -> S_HALT.
- S_HALT:
  - `halt` = 1 and `in_ready` = 0.
  - Only reset leaves S_HALT.
- Priority when several system flags are set at once: ebreak > ecall > mret.
- An instruction carrying a system flag also performs its GPR and CSR writes. The GPR write happens before the flag's own CSR side effects.

## Timing
- Reset values:
  - in_ready 1; rf_wen 0.
  - redirect_valid, flush, halt, retire_valid 0.
  - redirect_pc, halt_pc, retire_pc, retire_inst 0.
- GPR and CSR write latency: 0 cycles; the write commits on the acc edge.
- Retire record: `retire_valid`, `retire_pc` and `retire_inst` are registered and appear one cycle after acc. Each pulse lasts one cycle per accepted instruction, ebreak included.
- Redirect timing: `flush` and `redirect_valid` are asserted in the cycle after acc of an ecall or mret, for exactly 1 cycle. `in_ready` is 0 during that cycle.
- Back-to-back instructions: throughput is one per cycle in S_RUN.
- Reset mid-S_REDIR: the redirect is dropped and all CSRs return to their reset values.

## Configuration
- `WBU_COUNTERS_EN`: compiles in the performance counters.
- With the macro defined, two 64-bit counters exist:
  - mcycle increments every cycle out of reset.
  - minstret increments on each acc.
  - Both are readable at 0xB00/0xB80 (mcycle low/high) and 0xB02/0xB82 (minstret low/high).
  - Both are writable via CSR write; a write overrides that cycle's increment.
  - Wrap-around is modulo 2^64.
- Without the macro, no counter registers exist and those addresses read 0.

## Test plan
- Reset, then accept addi with rd=5, result=0x1234 -> rf_wen=1, rf_waddr=5, rf_wdata=0x1234 in the same cycle. Next cycle retire_valid=1 with the matching pc.
- csrw mtvec=0x8000_0100, then ecall at pc 0x8000_0040 -> one cycle later redirect_valid=flush=1 and redirect_pc=0x8000_0100. Also mepc=0x8000_0040, mcause=11, mstatus[3]=0, and in_ready=0 for that one cycle.
- Write mepc=0x8000_0200, then mret -> redirect_pc=0x8000_0200 and mstatus MIE takes the prior MPIE value.
- ebreak at pc 0x8000_0080 with in_valid held high afterwards -> halt=1, halt_pc=0x8000_0080, in_ready stays 0 for 100 cycles. Reset clears halt.
- Stream 10 back-to-back instructions with in_valid=1 -> 10 consecutive retire pulses. With WBU_COUNTERS_EN, reading 0xB02 gives 10.
- With WBU_COUNTERS_EN, write minstret low=0xFFFF_FFFF and high=0, then retire 1 instruction -> minstret low=0 and high=1.
